// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the 5-stage datapath (master) and hazard_stall_ctrl (slave).
// HAZ_STATS_EN adds the hazard statistics counters to the bundle.
interface hazard_stall_ctrl_if;
  // hazard / forwarding sources
  logic [3:0] id_rs_addr;
  logic [3:0] id_rt_addr;
  logic [3:0] ex_rs_addr;
  logic [3:0] ex_rt_addr;
  logic [3:0] ex_w_addr;
  logic       ex_mem_read;
  logic [3:0] mem_w_addr;
  logic       mem_reg_write;
  logic [3:0] wb_w_addr;
  logic       wb_reg_write;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  // pipeline controls
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_write;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       mem_err;
  logic [1:0] state_o;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt_o;
  logic [15:0] wait_cnt_o;
`endif

  modport master (
    output id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_w_addr, ex_mem_read,
           mem_w_addr, mem_reg_write, wb_w_addr, wb_reg_write, branch_taken,
           dmem_req, dmem_ready,
`ifdef HAZ_STATS_EN
    input  stall_cnt, flush_cnt_o, wait_cnt_o,
`endif
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           fwd_a_sel, fwd_b_sel, mem_err, state_o
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_w_addr, ex_mem_read,
           mem_w_addr, mem_reg_write, wb_w_addr, wb_reg_write, branch_taken,
           dmem_req, dmem_ready,
`ifdef HAZ_STATS_EN
    output stall_cnt, flush_cnt_o, wait_cnt_o,
`endif
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           fwd_a_sel, fwd_b_sel, mem_err, state_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage 8-bit pipeline: enables, bubbles, flushes, forwarding.
// Optional HAZ_STATS_EN adds saturating stall/flush/wait cycle counters.
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic            clk,
  input logic            rst_n,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_nxt;
  logic [7:0] wait_cnt, wait_nxt, wait_inc;
  logic       err_q, err_nxt;

  logic mem_wait, load_use;
  logic pc_w, ifid_w, idex_w, exmem_w, flush, bubble;
  logic [1:0] fwd_a, fwd_b;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign mem_wait = hz.dmem_req && !hz.dmem_ready;
  assign load_use = hz.ex_mem_read && (hz.ex_w_addr != 4'd0) &&
                    ((hz.ex_w_addr == hz.id_rs_addr) || (hz.ex_w_addr == hz.id_rt_addr));
  assign wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       mem_rw, input logic [3:0] mem_w,
    input logic       wb_rw,  input logic [3:0] wb_w
  );
    if (src == 4'd0)                   return 2'b00;
    if (mem_rw && (mem_w == src))      return 2'b01;
    if (wb_rw && (wb_w == src))        return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(hz.ex_rs_addr, hz.mem_reg_write, hz.mem_w_addr,
                         hz.wb_reg_write, hz.wb_w_addr);
  assign fwd_b = fwd_sel(hz.ex_rt_addr, hz.mem_reg_write, hz.mem_w_addr,
                         hz.wb_reg_write, hz.wb_w_addr);

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    wait_nxt  = wait_cnt;
    err_nxt   = err_q;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    idex_w    = 1'b1;
    exmem_w   = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    case (state)
      // LOAD_STALL has already injected its bubble; it just re-evaluates like RUN.
      RUN, LOAD_STALL: begin
        if (mem_wait) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end else if (hz.branch_taken) begin
          flush     = 1'b1;
          bubble    = 1'b1;
          flush_nxt = FLUSH_RELOAD;
          state_nxt = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
        end else if (load_use) begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          bubble    = 1'b1;
          state_nxt = LOAD_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      BR_FLUSH: begin
        if (mem_wait) begin
          // flush_cnt is held so the flush resumes once memory completes
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end else begin
          flush     = 1'b1;
          bubble    = 1'b1;
          flush_nxt = flush_cnt - 3'd1;
          state_nxt = (flush_cnt == 3'd1) ? RUN : BR_FLUSH;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_nxt = (flush_cnt != 3'd0) ? BR_FLUSH : RUN;
        end else if (wait_inc >= TIMEOUT) begin
          // give up on memory: flag it, drop any pending flush, let the pipe move
          err_nxt   = 1'b1;
          flush_nxt = 3'd0;
          state_nxt = RUN;
        end else begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          wait_nxt = wait_inc;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      wait_cnt  <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      wait_cnt  <= wait_nxt;
      err_q     <= err_nxt;
    end
  end

  // Reset holds the pipeline frozen and full of NOPs.
  assign hz.pc_write    = rst_n & pc_w;
  assign hz.ifid_write  = rst_n & ifid_w;
  assign hz.idex_write  = rst_n & idex_w;
  assign hz.exmem_write = rst_n & exmem_w;
  assign hz.ifid_flush  = !rst_n | flush;
  assign hz.idex_bubble = !rst_n | bubble;
  assign hz.fwd_a_sel   = rst_n ? fwd_a : 2'b00;
  assign hz.fwd_b_sel   = rst_n ? fwd_b : 2'b00;
  assign hz.mem_err     = err_q;
  assign hz.state_o     = state;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_q, flushc_q, waitc_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= 16'd0;
      flushc_q <= 16'd0;
      waitc_q  <= 16'd0;
    end else begin
      if (state == LOAD_STALL && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush && flushc_q != 16'hFFFF)              flushc_q <= flushc_q + 16'd1;
      if (state == MEM_WAIT && waitc_q != 16'hFFFF)   waitc_q <= waitc_q + 16'd1;
    end
  end

  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt_o = flushc_q;
  assign hz.wait_cnt_o  = waitc_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random traffic
// compared against an event-priority reference model.
module tb_hazard_stall_ctrl;
  localparam int FC = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_ctrl_if hz();

  hazard_stall_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );

  always #5 clk = ~clk;

  // reference model: pipeline situation, pending flush count, wait length, error flag
  int         m_st, m_fl, m_wc;
  bit         m_err;
  int         n_st, n_fl, n_wc;
  bit         n_err;
  logic [12:0] exp;

  function automatic logic [12:0] obs();
    return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write, hz.idex_bubble,
            hz.exmem_write, hz.fwd_a_sel, hz.fwd_b_sel, hz.mem_err, hz.state_o};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] src);
    if (src == 0) return 2'b00;
    if (hz.mem_reg_write && hz.mem_w_addr == src) return 2'b01;
    if (hz.wb_reg_write && hz.wb_w_addr == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit mw, lu, p, i, d, x, fl, bub;
    logic [1:0] st;
    mw = hz.dmem_req && !hz.dmem_ready;
    lu = hz.ex_mem_read && hz.ex_w_addr != 0 &&
         (hz.ex_w_addr == hz.id_rs_addr || hz.ex_w_addr == hz.id_rt_addr);
    {p, i, d, x} = 4'b1111; fl = 0; bub = 0;
    n_st = 0; n_fl = m_fl; n_wc = m_wc; n_err = m_err;
    if (!rst_n) begin
      exp = 13'b0_0_1_0_1_0_00_00_0_00;
      n_fl = 0; n_wc = 0; n_err = 0;
      return;
    end
    if (m_st == 3) begin
      if (hz.dmem_ready) n_st = (m_fl != 0) ? 2 : 0;
      else if (m_wc + 1 >= TO) begin n_err = 1; n_fl = 0; end
      else begin {p, i, d, x} = 4'b0000; n_st = 3; n_wc = (m_wc + 1 > 255) ? 255 : m_wc + 1; end
    end else if (mw) begin
      {p, i, d, x} = 4'b0000; n_st = 3; n_wc = 1;
    end else if (m_st == 2) begin
      fl = 1; bub = 1; n_fl = m_fl - 1; n_st = (n_fl != 0) ? 2 : 0;
    end else if (hz.branch_taken) begin
      fl = 1; bub = 1; n_fl = FC - 1; n_st = (FC > 1) ? 2 : 0;
    end else if (lu) begin
      p = 0; i = 0; bub = 1; n_st = 1;
    end
    st = 2'(m_st);
    exp = {p, i, fl, d, bub, x, m_fwd(hz.ex_rs_addr), m_fwd(hz.ex_rt_addr), m_err, st};
  endtask

  task automatic advance();
    @(negedge clk);
    m_st = n_st; m_fl = n_fl; m_wc = n_wc; m_err = n_err;
    #1;
  endtask

  task automatic idle();
    hz.id_rs_addr = 0; hz.id_rt_addr = 0; hz.ex_rs_addr = 0; hz.ex_rt_addr = 0;
    hz.ex_w_addr = 0; hz.ex_mem_read = 0; hz.mem_w_addr = 0; hz.mem_reg_write = 0;
    hz.wb_w_addr = 0; hz.wb_reg_write = 0; hz.branch_taken = 0;
    hz.dmem_req = 0; hz.dmem_ready = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) begin hz.dmem_req = 1; hz.dmem_ready = 0; end
      else idle();
      if (c == 2) rst_n = 1'b0;
      if (c == 3) rst_n = 1'b1;
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL reset_model cyc %0d got %b exp %b", c, obs(), exp); end
      if (c == 2) begin
        checks++;
        if ({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write, hz.idex_bubble, hz.state_o} !== 7'b0000_1_00) begin
          errors++; $display("FAIL reset_mid_wait got %b exp 0000100", {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write, hz.idex_bubble, hz.state_o});
        end
      end
      if (c == 3) begin
        checks++;
        if ({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write} !== 4'b1111) begin
          errors++; $display("FAIL reset_release got %b exp 1111", {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write});
        end
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 0) begin hz.ex_mem_read = 1; hz.ex_w_addr = 3; hz.id_rs_addr = 3; end
      if (c == 1) begin hz.mem_w_addr = 3; hz.mem_reg_write = 1; hz.ex_rs_addr = 3; end
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL load_use_model cyc %0d got %b exp %b", c, obs(), exp); end
      if (c == 0) begin
        checks++;
        if ({hz.pc_write, hz.idex_bubble} !== 2'b01) begin
          errors++; $display("FAIL load_use_stall got %b exp 01", {hz.pc_write, hz.idex_bubble});
        end
      end
      if (c == 1) begin
        checks++;
        if ({hz.fwd_a_sel, hz.pc_write, hz.idex_bubble} !== 4'b01_1_0) begin
          errors++; $display("FAIL load_use_fwd got %b exp 0110", {hz.fwd_a_sel, hz.pc_write, hz.idex_bubble});
        end
      end
      advance();
    end
  endtask

  task automatic test_r0();
    idle();
    hz.ex_mem_read = 1; hz.ex_w_addr = 0; hz.id_rt_addr = 0;
    hz.mem_reg_write = 1; hz.wb_reg_write = 1;
    #6; model_eval(); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL r0_model got %b exp %b", obs(), exp); end
    checks++;
    if ({hz.pc_write, hz.idex_bubble, hz.fwd_a_sel, hz.fwd_b_sel} !== 6'b10_0000) begin
      errors++; $display("FAIL r0_no_stall got %b exp 100000", {hz.pc_write, hz.idex_bubble, hz.fwd_a_sel, hz.fwd_b_sel});
    end
    advance();
  endtask

  task automatic test_branch();
    for (int c = 0; c < 3; c++) begin
      idle();
      hz.branch_taken = (c == 0);
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL branch_model cyc %0d got %b exp %b", c, obs(), exp); end
      checks++;
      if ({hz.ifid_flush, hz.idex_bubble} !== ((c < 2) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL branch_flush cyc %0d got %b", c, {hz.ifid_flush, hz.idex_bubble});
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 4 + TO + 3; c++) begin
      idle();
      if (c < 3 || (c >= 4 && c < 4 + TO)) hz.dmem_req = 1;
      if (c == 3) begin hz.dmem_req = 1; hz.dmem_ready = 1; end
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL mem_wait_model cyc %0d got %b exp %b", c, obs(), exp); end
      if (c < 3 || c == 3) begin
        checks++;
        if ({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write} !== ((c < 3) ? 4'b0000 : 4'b1111)) begin
          errors++; $display("FAIL mem_wait_en cyc %0d got %b", c, {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write});
        end
      end
      if (c >= 4 + TO) begin
        checks++;
        if (hz.mem_err !== 1'b1) begin errors++; $display("FAIL mem_err_sticky cyc %0d got %b exp 1", c, hz.mem_err); end
      end
      advance();
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin
        hz.branch_taken = 1; hz.ex_mem_read = 1; hz.ex_w_addr = 4; hz.id_rs_addr = 4;
        hz.dmem_req = 1;
      end
      if (c == 1) hz.dmem_ready = 1;
      if (c >= 2) begin
        hz.mem_reg_write = 1; hz.mem_w_addr = 5; hz.wb_reg_write = 1; hz.wb_w_addr = (c == 2) ? 5 : 6;
        hz.ex_rs_addr = (c == 2) ? 5 : 6; hz.ex_rt_addr = 5;
      end
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL priority_model cyc %0d got %b exp %b", c, obs(), exp); end
      if (c == 1) begin
        checks++;
        if (hz.state_o !== 2'd3) begin errors++; $display("FAIL priority_memwait got %0d exp 3", hz.state_o); end
      end
      if (c >= 2) begin
        checks++;
        if ({hz.fwd_a_sel, hz.fwd_b_sel} !== ((c == 2) ? 4'b0101 : 4'b1001)) begin
          errors++; $display("FAIL fwd_prio cyc %0d got %b", c, {hz.fwd_a_sel, hz.fwd_b_sel});
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    // branch flush preempted by a memory wait, then resumed
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) hz.branch_taken = 1;
      if (c == 1 || c == 2) hz.dmem_req = 1;
      if (c == 3) begin hz.dmem_req = 1; hz.dmem_ready = 1; end
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL b2b_model cyc %0d got %b exp %b", c, obs(), exp); end
      if (c == 4) begin
        checks++;
        if ({hz.state_o, hz.ifid_flush} !== 3'b10_1) begin
          errors++; $display("FAIL flush_resume got %b exp 101", {hz.state_o, hz.ifid_flush});
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      hz.id_rs_addr = 4'($urandom_range(0, 7)); hz.id_rt_addr = 4'($urandom_range(0, 7));
      hz.ex_rs_addr = 4'($urandom_range(0, 7)); hz.ex_rt_addr = 4'($urandom_range(0, 7));
      hz.ex_w_addr = 4'($urandom_range(0, 7));  hz.ex_mem_read = ($urandom_range(0, 9) < 3);
      hz.mem_w_addr = 4'($urandom_range(0, 7)); hz.mem_reg_write = $urandom_range(0, 1);
      hz.wb_w_addr = 4'($urandom_range(0, 7));  hz.wb_reg_write = $urandom_range(0, 1);
      hz.branch_taken = ($urandom_range(0, 9) == 0);
      hz.dmem_req = ($urandom_range(0, 4) == 0);
      hz.dmem_ready = $urandom_range(0, 1);
      #6; model_eval(); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL random cyc %0d got %b exp %b", c, obs(), exp); end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    m_st = 0; m_fl = 0; m_wc = 0; m_err = 0;
    n_st = 0; n_fl = 0; n_wc = 0; n_err = 0;
    @(negedge clk); #1;
    #6; model_eval(); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL reset_state got %b exp %b", obs(), exp); end
    advance();
    test_reset();
    test_load_use();
    test_r0();
    test_branch();
    test_mem_wait();
    test_priority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
